// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with occupancy flags, sticky overflow/underflow errors and a
// hysteretic pause output driven by programmable almost-empty/almost-full watermarks.
module fifo_flow_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_WORD_SIZE = 10,
    parameter int FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold_input,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold_input,
    input  logic                      wr_en,
    input  logic [FIFO_WORD_SIZE-1:0] data_in,
    input  logic                      rd_en,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      valid,
    output logic [FIFO_PTR_SIZE:0]    count,
    output logic                      empty_flag,
    output logic                      full_flag,
    output logic                      almost_empty_flag,
    output logic                      almost_full_flag,
    output logic                      overflow_err,
    output logic                      underflow_err,
    output logic                      pause
);

    localparam logic [FIFO_PTR_SIZE:0]   DEPTH_C  = (FIFO_PTR_SIZE+1)'(FIFO_DEPTH);
    localparam logic [FIFO_PTR_SIZE-1:0] AE_RST_C = FIFO_PTR_SIZE'(2);
    localparam logic [FIFO_PTR_SIZE-1:0] AF_RST_C = FIFO_PTR_SIZE'(FIFO_DEPTH - 2);

    typedef enum logic {RUN, PAUSE} state_e;

    logic [FIFO_WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_SIZE:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFO_WORD_SIZE-1:0] data_out_q;
    logic                      valid_q;
    logic                      ovf_q, ovf_d, udf_q, udf_d;
    logic [FIFO_PTR_SIZE-1:0]  ae_th_q, af_th_q;
    logic [FIFO_PTR_SIZE:0]    ae_ext, af_ext;
    state_e                    state_q, state_d;
    logic                      push_ok, pop_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign ae_ext  = {1'b0, ae_th_q};
    assign af_ext  = {1'b0, af_th_q};
    assign pop_ok  = rd_en && (count != '0);
    assign push_ok = wr_en && ((count < DEPTH_C) || pop_ok);

    assign ovf_d = init ? 1'b0 : (ovf_q || (wr_en && !push_ok));
    assign udf_d = init ? 1'b0 : (udf_q || (rd_en && !pop_ok));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[FIFO_PTR_SIZE-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            ae_th_q    <= AE_RST_C;
            af_th_q    <= AF_RST_C;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                data_out_q <= mem_q[rd_ptr_q[FIFO_PTR_SIZE-1:0]];
            end
            valid_q <= pop_ok;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            if (init) begin
                ae_th_q <= almost_empty_threshold_input;
                af_th_q <= almost_full_threshold_input;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Hysteresis: assert at the high watermark, release only at the low one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if ((count >= af_ext) || (count == DEPTH_C)) state_d = PAUSE;
            PAUSE:   if (count <= ae_ext) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pause = (state_q == PAUSE);
    end

    assign data_out          = data_out_q;
    assign valid             = valid_q;
    assign overflow_err      = ovf_q;
    assign underflow_err     = udf_q;
    assign empty_flag        = reset || (count == '0);
    assign full_flag         = !reset && (count == DEPTH_C);
    assign almost_empty_flag = !reset && (count != '0) && (count <= ae_ext);
    assign almost_full_flag  = !reset && (count >= af_ext) && (count < DEPTH_C);

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl at depth 8, 10-bit words.
module tb_fifo_flow_ctrl;
    localparam int DEPTH = 8;
    localparam int W     = 10;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          reset, init, wr_en, rd_en;
    logic [PW-1:0] ae_in, af_in;
    logic [W-1:0]  data_in, data_out;
    logic          valid, empty_flag, full_flag, almost_empty_flag, almost_full_flag;
    logic          overflow_err, underflow_err, pause;
    logic [PW:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_flow_ctrl #(.FIFO_DEPTH(DEPTH), .FIFO_WORD_SIZE(W)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .init                         (init),
        .almost_empty_threshold_input (ae_in),
        .almost_full_threshold_input  (af_in),
        .wr_en                        (wr_en),
        .data_in                      (data_in),
        .rd_en                        (rd_en),
        .data_out                     (data_out),
        .valid                        (valid),
        .count                        (count),
        .empty_flag                   (empty_flag),
        .full_flag                    (full_flag),
        .almost_empty_flag            (almost_empty_flag),
        .almost_full_flag             (almost_full_flag),
        .overflow_err                 (overflow_err),
        .underflow_err                (underflow_err),
        .pause                        (pause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        init  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] exp_w;
        reset = 1'b1; init = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        ae_in = '0; af_in = '0; data_in = '0;
        tick();
        check("rst_count",    32'(count), 32'd0);
        check("rst_valid",    32'(valid), 32'd0);
        check("rst_dout",     32'(data_out), 32'd0);
        check("rst_empty",    32'(empty_flag), 32'd1);
        check("rst_full",     32'(full_flag), 32'd0);
        check("rst_ae",       32'(almost_empty_flag), 32'd0);
        check("rst_af",       32'(almost_full_flag), 32'd0);
        check("rst_ovf",      32'(overflow_err), 32'd0);
        check("rst_udf",      32'(underflow_err), 32'd0);
        check("rst_pause",    32'(pause), 32'd0);
        // Push attempt while reset held must be ignored.
        wr_en = 1'b1; data_in = 10'h2AA;
        tick();
        check("rst_hold_count", 32'(count), 32'd0);
        check("rst_hold_empty", 32'(empty_flag), 32'd1);
        reset = 1'b0; idle();

        // Fill 0x001..0x008 with default watermarks AE=2, AF=6.
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = 1'b1; data_in = 10'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            if (i == 1) check("fill_ae1", 32'(almost_empty_flag), 32'd1);
            if (i == 3) check("fill_ae3", 32'(almost_empty_flag), 32'd0);
            if (i == 6) check("fill_af6", 32'(almost_full_flag), 32'd1);
        end
        idle();
        check("full_flag",  32'(full_flag), 32'd1);
        check("full_af",    32'(almost_full_flag), 32'd0);
        check("full_empty", 32'(empty_flag), 32'd0);
        check("full_pause", 32'(pause), 32'd1);

        // Rejected push while full.
        wr_en = 1'b1; data_in = 10'h3FF;
        tick();
        check("ovf_set",   32'(overflow_err), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        wr_en = 1'b0; init = 1'b1; ae_in = 3'd2; af_in = 3'd6;
        tick();
        check("ovf_clear", 32'(overflow_err), 32'd0);
        idle();

        // Drain in order; 0x3FF must never appear.
        for (int i = 1; i <= DEPTH; i++) begin
            rd_en = 1'b1;
            tick();
            check("drain_valid", 32'(valid), 32'd1);
            check("drain_data",  32'(data_out), 32'(i));
            check("drain_count", 32'(count), 32'(DEPTH - i));
        end
        idle();
        tick();
        check("post_valid", 32'(valid), 32'd0);
        check("post_hold",  32'(data_out), 32'h008);
        check("post_empty", 32'(empty_flag), 32'd1);
        check("post_pause", 32'(pause), 32'd0);

        // Refill, then simultaneous push/pop while full.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; data_in = 10'h011 + 10'(i);
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 10'h021 + 10'(j);
            tick();
            check("fullrw_valid", 32'(valid), 32'd1);
            check("fullrw_data",  32'(data_out), 32'h011 + 32'(j));
            check("fullrw_count", 32'(count), 32'd8);
        end
        check("fullrw_ovf", 32'(overflow_err), 32'd0);
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            rd_en = 1'b1;
            exp_w = (k < 5) ? (10'h014 + 10'(k)) : (10'h021 + 10'(k - 5));
            tick();
            check("fullrw_drain", 32'(data_out), 32'(exp_w));
        end
        idle();
        check("fullrw_empty", 32'(empty_flag), 32'd1);

        // Underflow, init priority over a same-cycle error, push+pop on empty.
        rd_en = 1'b1;
        tick();
        check("udf_set",   32'(underflow_err), 32'd1);
        check("udf_valid", 32'(valid), 32'd0);
        rd_en = 1'b1; init = 1'b1; ae_in = 3'd1; af_in = 3'd5;
        tick();
        check("udf_init_prio", 32'(underflow_err), 32'd0);
        idle();
        wr_en = 1'b1; rd_en = 1'b1; data_in = 10'h055;
        tick();
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_udf",   32'(underflow_err), 32'd1);
        check("emptyrw_valid", 32'(valid), 32'd0);
        idle(); rd_en = 1'b1;
        tick();
        check("emptyrw_pop_valid", 32'(valid), 32'd1);
        check("emptyrw_pop_data",  32'(data_out), 32'h055);
        check("emptyrw_pop_count", 32'(count), 32'd0);
        idle(); init = 1'b1; ae_in = 3'd1; af_in = 3'd5;
        tick();
        check("udf_clear", 32'(underflow_err), 32'd0);
        idle();

        // Pause hysteresis with AE=1, AF=5.
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; data_in = 10'h100 + 10'(i);
            tick();
        end
        idle();
        check("hyst_count5", 32'(count), 32'd5);
        check("hyst_af5",    32'(almost_full_flag), 32'd1);
        tick();
        check("hyst_pause_on", 32'(pause), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            rd_en = 1'b1;
            tick();
            check("hyst_pop", 32'(data_out), 32'h100 + 32'(i));
        end
        idle();
        tick();
        check("hyst_count2", 32'(count), 32'd2);
        check("hyst_pause2", 32'(pause), 32'd1);
        rd_en = 1'b1;
        tick();
        idle();
        check("hyst_ae1", 32'(almost_empty_flag), 32'd1);
        tick();
        check("hyst_pause_off", 32'(pause), 32'd0);
        rd_en = 1'b1;
        tick();
        idle();
        check("hyst_last", 32'(data_out), 32'h105);

        // Wrap-around with occupancy 4, then reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; data_in = 10'h200 + 10'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 10'h204 + 10'(i);
            tick();
            check("wrap_data",  32'(data_out), 32'h200 + 32'(i));
            check("wrap_count", 32'(count), 32'd4);
        end
        idle();
        check("wrap_final", 32'(count), 32'd4);
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 10'h3AA;
        tick();
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty_flag), 32'd1);
        check("midrst_valid", 32'(valid), 32'd0);
        reset = 1'b0; idle();
        wr_en = 1'b1; data_in = 10'h077;
        tick();
        idle();
        check("postrst_ae_default", 32'(almost_empty_flag), 32'd1);
        rd_en = 1'b1;
        tick();
        idle();
        check("postrst_data", 32'(data_out), 32'h077);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fifo_flow_ctrl.md
FIFO_FLOW_CTRL -- requirements
Module: fifo_flow_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning entry count; power of 2, >= 4.
REQ-002 SHALL have parameter FIFO_WORD_SIZE, default 10, meaning data width in bits.
REQ-003 SHALL have parameter FIFO_PTR_SIZE, default $clog2(FIFO_DEPTH), meaning pointer and threshold width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, meaning reset that is synchronous and active-high.
REQ-006 SHALL have port init, input, 1, meaning load thresholds and clear sticky errors.
REQ-007 SHALL have port almost_empty_threshold_input, input, FIFO_PTR_SIZE, meaning low watermark loaded on init.
REQ-008 SHALL have port almost_full_threshold_input, input, FIFO_PTR_SIZE, meaning high watermark loaded on init.
REQ-009 SHALL have port wr_en, input, 1, meaning push request.
REQ-010 SHALL have port data_in, input, FIFO_WORD_SIZE, meaning push data.
REQ-011 SHALL have port rd_en, input, 1, meaning pop request.
REQ-012 SHALL have port data_out, output, FIFO_WORD_SIZE, meaning registered pop data.
REQ-013 SHALL have port valid, output, 1, meaning data_out holds a popped word this cycle.
REQ-014 SHALL have port count, output, FIFO_PTR_SIZE+1, meaning current occupancy 0..FIFO_DEPTH.
REQ-015 SHALL have outputs empty_flag, full_flag, almost_empty_flag and almost_full_flag, each 1 bit, meaning occupancy status.
REQ-016 SHALL have outputs overflow_err and underflow_err, each 1 bit, meaning sticky error indications.
REQ-017 SHALL have port pause, output, 1, meaning hysteretic back-pressure to the upstream producer.

Function
REQ-018 SHALL use wr_ptr and rd_ptr of FIFO_PTR_SIZE+1 bits, with the MSB as wrap bit; count = wr_ptr - rd_ptr, modulo 2^(FIFO_PTR_SIZE+1).
REQ-019 SHALL accept a push when wr_en=1 and (count<FIFO_DEPTH, or rd_en=1 with count>0); it writes data_in at wr_ptr and increments wr_ptr.
REQ-020 SHALL accept a pop when rd_en=1 and count>0; data_out <= mem[rd_ptr], valid=1 on the next cycle, and rd_ptr increments.
REQ-021 SHALL drive valid=0 and hold data_out at its last value in any cycle following no accepted pop.
REQ-022 SHALL accept both operations when push and pop occur together while full; count is unchanged and the pop returns the oldest word.
REQ-023 SHALL, on push and pop together while empty, ignore the pop, set underflow_err, accept the push, and end with count=1.
REQ-024 SHALL drop a rejected push (wr_en=1, full, rd_en=0), leave memory and pointers unchanged, and set overflow_err on the next edge.
REQ-025 SHALL ignore a rejected pop (rd_en=1, empty), keep valid=0, and set underflow_err on the next edge.
REQ-026 SHALL decode flags combinationally from the registered count: empty_flag=(count==0), full_flag=(count==FIFO_DEPTH), almost_empty_flag=(0<count<=AE_th), almost_full_flag=(AF_th<=count<FIFO_DEPTH).
REQ-027 SHALL implement a two-state pause FSM. RUN goes to PAUSE when count>=AF_th or full. PAUSE goes to RUN when count<=AE_th. pause=1 in PAUSE, registered.
REQ-028 SHALL, with init=1, load AE_th/AF_th from the inputs and clear both sticky errors on that edge; FIFO contents, pointers and push/pop continue normally.
REQ-029 SHALL give init priority over an error set in the same cycle; the error is cleared.
REQ-030 SHALL wrap pointers naturally; no entry is lost or duplicated across repeated wrap-around.

Reset
REQ-031 SHALL, on reset=1 at posedge, set wr_ptr=rd_ptr=0, count=0, valid=0, data_out=0, overflow_err=underflow_err=0, FSM=RUN, AE_th=2 and AF_th=FIFO_DEPTH-2.
REQ-032 SHALL give reset priority over init, wr_en and rd_en; reset mid-operation discards all contents, and memory array contents need not be cleared.
REQ-033 SHALL hold flags at empty_flag=1 and all others 0 while reset is active.

Verification (FIFO_DEPTH=8, FIFO_WORD_SIZE=10)
REQ-034 SHALL cover: after reset, push 0x001..0x008 and then pop 8 -> count 8, full_flag=1; data_out 0x001..0x008 in order, each with valid one cycle after rd_en.
REQ-035 SHALL cover: while full, wr_en 0x3FF -> overflow_err=1, count stays 8, and 0x3FF is never read; then init=1 -> overflow_err=0.
REQ-036 SHALL cover: while full, wr_en and rd_en together for 3 cycles -> count stays 8 and the output sequence is oldest-first with new words appended.
REQ-037 SHALL cover: while empty, rd_en alone -> underflow_err=1, valid=0; while empty, wr_en and rd_en together -> count=1.
REQ-038 SHALL cover: init with AE=1, AF=5, fill to 5 -> pause=1; drain to 2 -> pause stays 1; drain to 1 -> pause=0.
REQ-039 SHALL cover: 20 push/pop cycles spanning pointer wrap, then reset at count=4 -> next cycle count=0, empty_flag=1, valid=0.
